// File: rtl/next_pc_unit.sv
// Program counter and next-PC resolution: decodes the 4-bit branch-select code,
// evaluates signed compares, issues the jal link write and one bubble per redirect.
module next_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             instr_valid,
  input  logic [3:0]       branch,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  input  logic [15:0]      imm,
  input  logic [25:0]      target,
  output logic [31:0]      pc,
  output logic             pc_valid,
  output logic             link_we,
  output logic [31:0]      link_addr,
  output logic             illegal,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {BOOT, RUN, REDIRECT} state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      link_addr_q, link_addr_d;
  logic             pc_valid_q, pc_valid_d;
  logic             link_we_q, link_we_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0]        pc4, br_tgt, jmp_tgt, tgt;
  logic signed [31:0] rs_s, rt_s;
  logic               taken, is_jal, rsvd;

  assign pc4     = pc_q + 32'd4;
  assign br_tgt  = pc4 + {{14{imm[15]}}, imm, 2'b00};
  assign jmp_tgt = {pc4[31:28], target, 2'b00};
  assign rs_s    = rs_val;
  assign rt_s    = rt_val;

  always_comb begin
    taken  = 1'b0;
    tgt    = br_tgt;
    is_jal = 1'b0;
    rsvd   = 1'b0;
    case (branch)
      4'b0000: ;
      4'b0001: begin taken = 1'b1; tgt = jmp_tgt; end
      4'b0010: begin taken = 1'b1; tgt = rs_val; end
      4'b0011: taken = (rs_s == rt_s);
      4'b0100: taken = (rs_s != rt_s);
      4'b0101: taken = (rs_s <= 32'sd0);
      4'b0110: taken = (rs_s >  32'sd0);
      4'b0111: taken = (rs_s <  rt_s);
      4'b1000: taken = (rs_s >  rt_s);
      4'b1001: taken = (rs_s >= rt_s);
      4'b1010: taken = (rs_s <= rt_s);
      4'b1011: begin taken = 1'b1; tgt = jmp_tgt; is_jal = 1'b1; end
      default: rsvd = 1'b1;
    endcase
  end

  // Pulses default low every cycle (including stall); everything else holds.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_valid_d  = pc_valid_q;
    link_addr_d = link_addr_q;
    cnt_d       = cnt_q;
    link_we_d   = 1'b0;
    illegal_d   = 1'b0;
    if (!stall) begin
      case (state_q)
        BOOT: begin
          state_d    = RUN;
          pc_valid_d = 1'b1;
        end
        REDIRECT: begin
          state_d    = RUN;
          pc_valid_d = 1'b1;
        end
        default: begin
          if (instr_valid) begin
            if (taken) begin
              state_d    = REDIRECT;
              pc_d       = tgt;
              pc_valid_d = 1'b0;
              cnt_d      = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
              if (is_jal) begin
                link_we_d   = 1'b1;
                link_addr_d = pc4;
              end
            end else begin
              pc_d      = pc4;
              illegal_d = rsvd;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      pc_valid_q  <= 1'b0;
      link_we_q   <= 1'b0;
      link_addr_q <= '0;
      illegal_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_valid_q  <= pc_valid_d;
      link_we_q   <= link_we_d;
      link_addr_q <= link_addr_d;
      illegal_q   <= illegal_d;
      cnt_q       <= cnt_d;
    end
  end

  assign pc        = pc_q;
  assign pc_valid  = pc_valid_q;
  assign link_we   = link_we_q;
  assign link_addr = link_addr_q;
  assign illegal   = illegal_q;
  assign taken_cnt = cnt_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Bench for next_pc_unit: directed scenarios plus random traffic, checked against
// a per-cycle reference built from the branch rules (two instances, CNT_W 16 and 2).
module tb_next_pc_unit;

  logic        clk = 1'b0;
  logic        rst, stall, instr_valid;
  logic [3:0]  branch;
  logic [31:0] rs_val, rt_val;
  logic [15:0] imm;
  logic [25:0] target;

  logic [31:0] pc, link_addr, pc2, link_addr2;
  logic        pc_valid, link_we, illegal, pc_valid2, link_we2, illegal2;
  logic [15:0] taken_cnt;
  logic [1:0]  taken_cnt2;

  int tests = 0;
  int fails = 0;

  next_pc_unit #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .instr_valid(instr_valid),
    .branch(branch), .rs_val(rs_val), .rt_val(rt_val), .imm(imm), .target(target),
    .pc(pc), .pc_valid(pc_valid), .link_we(link_we), .link_addr(link_addr),
    .illegal(illegal), .taken_cnt(taken_cnt));

  next_pc_unit #(.RESET_PC(32'h0000_0000), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .stall(stall), .instr_valid(instr_valid),
    .branch(branch), .rs_val(rs_val), .rt_val(rt_val), .imm(imm), .target(target),
    .pc(pc2), .pc_valid(pc_valid2), .link_we(link_we2), .link_addr(link_addr2),
    .illegal(illegal2), .taken_cnt(taken_cnt2));

  always #5 clk = ~clk;

  // Reference state
  bit          m_boot, m_bubble;
  logic [31:0] m_pc, m_laddr;
  bit          m_valid, m_lwe, m_ill;
  int unsigned m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_taken(input logic [3:0] code, input int signed a, input int signed b);
    case (code)
      4'd1, 4'd2, 4'd11: return 1'b1;
      4'd3:  return a == b;
      4'd4:  return a != b;
      4'd5:  return a <= 0;
      4'd6:  return a > 0;
      4'd7:  return a < b;
      4'd8:  return a > b;
      4'd9:  return a >= b;
      4'd10: return a <= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    logic        r, s, iv;
    logic [3:0]  c;
    logic [31:0] a, b, p4, dest;
    logic [15:0] im;
    logic [25:0] tg;
    r = rst; s = stall; iv = instr_valid; c = branch; a = rs_val; b = rt_val;
    im = imm; tg = target;
    @(posedge clk);
    #1;
    if (r) begin
      m_boot = 1; m_bubble = 0; m_pc = 32'h0; m_valid = 0;
      m_lwe = 0; m_laddr = 32'h0; m_ill = 0; m_cnt = 0;
    end else begin
      m_lwe = 0; m_ill = 0;
      if (!s) begin
        if (m_boot || m_bubble) begin
          m_boot = 0; m_bubble = 0; m_valid = 1;
        end else if (iv) begin
          p4 = m_pc + 32'd4;
          if (ref_taken(c, a, b)) begin
            if (c == 4'd2) dest = a;
            else if (c == 4'd1 || c == 4'd11) dest = {p4[31:28], tg, 2'b00};
            else dest = p4 + (32'(signed'(im)) * 4);
            m_pc = dest; m_bubble = 1; m_valid = 0; m_cnt++;
            if (c == 4'd11) begin m_lwe = 1; m_laddr = p4; end
          end else begin
            m_pc = p4;
            m_ill = (c >= 4'd12);
          end
        end
      end
    end
    chk("pc", pc, m_pc);
    chk("pc_valid", {31'b0, pc_valid}, {31'b0, m_valid});
    chk("link_we", {31'b0, link_we}, {31'b0, m_lwe});
    chk("link_addr", link_addr, m_laddr);
    chk("illegal", {31'b0, illegal}, {31'b0, m_ill});
    chk("taken_cnt", {16'b0, taken_cnt}, (m_cnt > 32'hFFFF) ? 32'hFFFF : m_cnt);
    chk("taken_cnt_w2", {30'b0, taken_cnt2}, (m_cnt > 3) ? 32'd3 : m_cnt);
    chk("pc_w2", pc2, m_pc);
  endtask

  task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] im, input logic [25:0] tg);
    branch = c; rs_val = a; rt_val = b; imm = im; target = tg;
  endtask

  logic [3:0] sc_code [5] = '{4'd7, 4'd8, 4'd5, 4'd6, 4'd9};
  bit         sc_tk   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] held_pc;

  initial begin
    rst = 1; stall = 0; instr_valid = 1;
    drive(4'd0, 32'd0, 32'd0, 16'd0, 26'd0);
    tick();
    chk("boot_pc", pc, 32'h0);
    chk("boot_valid", {31'b0, pc_valid}, 32'd0);
    rst = 0;
    tick();
    chk("run_pc0", pc, 32'h0);
    chk("run_valid", {31'b0, pc_valid}, 32'd1);
    tick(); chk("seq_4", pc, 32'h4);
    tick(); chk("seq_8", pc, 32'h8);
    tick(); chk("seq_c", pc, 32'hC);
    chk("seq_cnt", {16'b0, taken_cnt}, 32'd0);
    tick(); chk("at_10", pc, 32'h10);

    // beq taken backwards
    drive(4'd3, 32'd5, 32'd5, 16'hFFFC, 26'd0);
    tick();
    chk("beq_pc", pc, 32'h4);
    chk("beq_bubble", {31'b0, pc_valid}, 32'd0);
    chk("beq_cnt", {16'b0, taken_cnt}, 32'd1);
    drive(4'd0, 32'd0, 32'd0, 16'd0, 26'd0);
    tick(); chk("beq_resume", {31'b0, pc_valid}, 32'd1);
    tick(); tick(); tick(); chk("back_10", pc, 32'h10);
    drive(4'd3, 32'd5, 32'd6, 16'hFFFC, 26'd0);
    tick();
    chk("beq_nt_pc", pc, 32'h14);
    chk("beq_nt_valid", {31'b0, pc_valid}, 32'd1);

    // jal / jr
    drive(4'd2, 32'h2000_0040, 32'd0, 16'd0, 26'd0);
    tick();
    drive(4'd0, 32'd0, 32'd0, 16'd0, 26'd0);
    tick(); chk("jr_pc", pc, 32'h2000_0040);
    drive(4'd11, 32'd0, 32'd0, 16'd0, 26'h00_0100);
    tick();
    chk("jal_pc", pc, 32'h2000_0400);
    chk("jal_we", {31'b0, link_we}, 32'd1);
    chk("jal_addr", link_addr, 32'h2000_0044);
    drive(4'd0, 32'd0, 32'd0, 16'd0, 26'd0);
    tick(); chk("jal_we_off", {31'b0, link_we}, 32'd0);
    drive(4'd2, 32'h2000_0044, 32'd0, 16'd0, 26'd0);
    tick();
    chk("ret_pc", pc, 32'h2000_0044);
    chk("ret_we", {31'b0, link_we}, 32'd0);
    drive(4'd0, 32'd0, 32'd0, 16'd0, 26'd0);
    tick();

    // signed compares, rs=-1 rt=1
    for (int i = 0; i < 5; i++) begin
      drive(sc_code[i], 32'hFFFF_FFFF, 32'd1, 16'h0010, 26'd0);
      tick();
      chk("signed_cmp", {31'b0, pc_valid}, {31'b0, !sc_tk[i]});
      if (sc_tk[i]) begin
        drive(4'd0, 32'd0, 32'd0, 16'd0, 26'd0);
        tick();
      end
    end

    // stall held across the redirect bubble
    drive(4'd1, 32'd0, 32'd0, 16'd0, 26'h40);
    tick();
    held_pc = pc;
    stall = 1;
    drive(4'd2, 32'h1234_5678, 32'd0, 16'd0, 26'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", pc, held_pc);
      chk("stall_valid", {31'b0, pc_valid}, 32'd0);
    end
    stall = 0;
    drive(4'd0, 32'd0, 32'd0, 16'd0, 26'd0);
    tick(); chk("stall_resume", {31'b0, pc_valid}, 32'd1);

    // reserved code
    held_pc = pc;
    drive(4'hE, 32'd0, 32'd0, 16'd0, 26'd0);
    tick();
    chk("ill_pulse", {31'b0, illegal}, 32'd1);
    chk("ill_pc", pc, held_pc + 32'd4);
    drive(4'd0, 32'd0, 32'd0, 16'd0, 26'd0);
    tick(); chk("ill_off", {31'b0, illegal}, 32'd0);

    // wrap at top of address space
    drive(4'd2, 32'hFFFF_FFFC, 32'd0, 16'd0, 26'd0);
    tick();
    drive(4'd0, 32'd0, 32'd0, 16'd0, 26'd0);
    tick(); tick();
    chk("wrap_pc", pc, 32'h0);

    // reset during REDIRECT drops the pending link write
    drive(4'd11, 32'd0, 32'd0, 16'd0, 26'h3FF_FFFF);
    tick();
    rst = 1;
    tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_we", {31'b0, link_we}, 32'd0);
    chk("rst_valid", {31'b0, pc_valid}, 32'd0);
    rst = 0;
    drive(4'd0, 32'd0, 32'd0, 16'd0, 26'd0);
    tick();

    // saturation of the narrow counter
    for (int i = 0; i < 4; i++) begin
      drive(4'd1, 32'd0, 32'd0, 16'd0, 26'(i * 16));
      tick();
      drive(4'd0, 32'd0, 32'd0, 16'd0, 26'd0);
      tick();
    end
    chk("sat_w2", {30'b0, taken_cnt2}, 32'd3);
    chk("sat_w16", {16'b0, taken_cnt}, 32'd4);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] pool [6];
      pool[0] = 32'd0; pool[1] = 32'd1; pool[2] = 32'hFFFF_FFFF;
      pool[3] = 32'h7FFF_FFFF; pool[4] = 32'h8000_0000; pool[5] = $urandom;
      rst         = ($urandom_range(0, 99) < 2);
      stall       = ($urandom_range(0, 99) < 12);
      instr_valid = ($urandom_range(0, 99) < 85);
      drive(4'($urandom_range(0, 15)), pool[$urandom_range(0, 5)],
            pool[$urandom_range(0, 5)], 16'($urandom), 26'($urandom));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/next_pc_unit.md
Name: next_pc_unit

Overview:
- Consumer end of the 4-bit branch-select bus driven by the control unit.
- Holds the program counter and resolves the next PC from the branch code, register operands, immediate and jump target.
- Issues the jal link write and the fetch-valid handshake to instruction memory.
- Sits between decode/register-read and instruction fetch; inserts one bubble after every redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 16, width of saturating taken-redirect counter

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous active-high reset
stall  input  1  hold all state; outputs keep their values
instr_valid  input  1  branch/rs/rt/imm/target describe the instruction at pc
branch  input  4  branch-select code from control unit
rs_val  input  32  register rs read data
rt_val  input  32  register rt read data
imm  input  16  instruction immediate
target  input  26  instruction jump index
pc  output  32  current fetch address
pc_valid  output  1  pc is a real fetch (0 during bubble)
link_we  output  1  one-cycle pulse: write link_addr to $31
link_addr  output  32  return address for jal
illegal  output  1  one-cycle pulse: reserved branch code seen
taken_cnt  output  CNT_W  count of redirects, saturating

Behaviour:
- Branch codes: 0000 pc_plus4, 0001 j, 0010 jr, 0011 beq, 0100 bne, 0101 blez, 0110 bgtz, 0111 blt, 1000 bgt, 1001 bge, 1010 ble, 1011 jal; 1100-1111 reserved.
- pc4 = pc+32'd4, modulo 2^32 (wraps 32'hFFFF_FFFC -> 0).
- Conditional targets: pc4 + (sign_extend(imm) << 2), modulo 2^32.
- j/jal target = {pc4[31:28], target, 2'b00}.
- jr target = rs_val.
- Comparisons are signed two's complement:
  - beq rs==rt; bne rs!=rt; blt rs<rt; bgt rs>rt; bge rs>=rt; ble rs<=rt.
  - blez rs<=0; bgtz rs>0.
- Taken = j, jr, jal, or conditional true. Otherwise the next PC is pc4.
- Reserved code: treated as pc_plus4, and illegal pulses high the next cycle.
- FSM states: BOOT, RUN, REDIRECT.
  - Reset: state=BOOT, pc=RESET_PC, pc_valid=0, link_we=0, link_addr=0, illegal=0, taken_cnt=0.
  - BOOT -> RUN after one cycle; pc unchanged, pc_valid=1 from the RUN cycle.
  - RUN, instr_valid=1, not taken: pc<=pc4; stay in RUN.
  - RUN, instr_valid=1, taken: pc<=target; state<=REDIRECT; pc_valid<=0; taken_cnt+1, saturating at all-ones.
  - RUN, instr_valid=0: pc holds; no pulses.
  - REDIRECT: all instruction inputs ignored; pc holds the target; next cycle -> RUN with pc_valid=1.
- jal: link_addr<=pc4 of the jal and link_we=1 for exactly one cycle, registered with the redirect. jr/j never assert link_we.
- Pulses: link_we and illegal are high only for the cycle after the qualifying RUN cycle; they deassert during stall.
- stall=1: state, pc, pc_valid, link_addr and taken_cnt frozen; pulses forced 0; inputs ignored. A redirect completes only on a non-stalled cycle.
- Priority: rst > stall > FSM.
- Reset in any state (including REDIRECT) returns to BOOT on that edge; a pending link_we is discarded.
- Latency: redirect visible on pc one cycle after the branch cycle. A taken branch costs 2 cycles: the branch cycle plus one bubble.

Test Plan:
- Reset then 4 idle cycles with instr_valid=1, branch=0000:
  - pc_valid=0 in BOOT.
  - pc sequence 0,0,4,8,C; taken_cnt=0.
- beq at pc=0x10, rs=rt=5, imm=16'hFFFC:
  - pc -> 0x04, REDIRECT bubble with pc_valid=0, taken_cnt=1.
  - Same stimulus with rt=6: pc -> 0x14, no bubble.
- jal at pc=0x2000_0040, target=26'h00_0100:
  - pc -> 0x2000_0400.
  - link_we one-cycle pulse with link_addr=0x2000_0044.
  - jr with rs_val=0x2000_0044 returns pc there; link_we stays 0.
- Signed compares with rs=32'hFFFF_FFFF (-1), rt=1:
  - blt taken, bgt not taken, blez taken, bgtz not taken, bge not taken.
- Stall and illegal:
  - Assert stall during the REDIRECT cycle: pc and pc_valid frozen for 3 cycles, then resume.
  - branch=4'b1110: pc+4 and one-cycle illegal pulse.
- Corner cases:
  - pc=32'hFFFF_FFFC with pc_plus4 wraps to 0.
  - Assert rst mid-REDIRECT: pc=RESET_PC, state BOOT, link_we=0.
  - With CNT_W=2, four taken branches leave taken_cnt=3.
